id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS core: registers the decode-stage control word (from the control unit) and operands into the execute stage. Contains load-use hazard detection with bubble insertion, branch/jump flush, and downstream hold. Drives the stall lines back to PC and IF/ID. Also keeps a saturating count of inserted load-use bubbles.

## Interface
- DATA_W, 32, datapath width (rd1, rd2, imm, pc4)
- REG_W, 5, register-address width
- CNT_W, 16, bubble-counter width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- regWrite_d, aluSrc_d, memWrite_d, memToReg_d, memRead_d, RegDst_d  in  1 each  decode control bits
- aluControl_d  in  3  decode ALU op
- rd1_d, rd2_d, imm_d, pc4_d  in  DATA_W each  register reads, sign-extended immediate, PC+4
- rs_d, rt_d, rd_d  in  REG_W each  register specifiers
- rt_used_d  in  1  decode instruction reads rt (R-type, sw, beq, bne)
- valid_d  in  1  IF/ID holds a real instruction
- flush  in  1  squash instruction entering EX (branch taken / jump)
- ex_hold  in  1  downstream cannot accept; freeze stage
- regWrite_e, aluSrc_e, memWrite_e, memToReg_e, memRead_e, RegDst_e  out  1 each  registered control
- aluControl_e  out  3
- rd1_e, rd2_e, imm_e, pc4_e  out  DATA_W each
- rs_e, rt_e, rd_e  out  REG_W each
- valid_e  out  1  EX holds a real instruction
- stall_f, stall_d  out  1 each  hold PC / hold IF/ID (combinational)
- bubble_cnt  out  CNT_W  load-use bubbles inserted

## Operation
- Hazard (combinational): hz = valid_e & memRead_e & (rt_e != 0) & valid_d & ((rt_e == rs_d) | (rt_used_d & (rt_e == rt_d))).
- Per-edge update priority, highest first:
  1. rst: all outputs 0, bubble_cnt 0.
  2. flush: load bubble.
  3. ex_hold: all registers keep their value.
  4. hz: load bubble; bubble_cnt += 1 (saturates at all-ones).
  5. otherwise: load all *_d into *_e, valid_e <= valid_d.
- Bubble = valid_e 0, every control output 0 (regWrite/memWrite/memRead cleared so no architectural effect), data/specifier fields 0.
- When valid_d=0 on a normal load, control outputs load as 0 regardless of inputs. This sanitises X from the control unit on unused fields (jump, branch, store).
- stall_f = stall_d = ~flush & (ex_hold | hz).
- flush never asserts a stall; flush with hz or ex_hold: flush wins, no count increment.
- ex_hold with hz: hold, no count increment (hazard re-evaluated next cycle).

## Timing
- Latency 1 cycle D→E on normal load.
- Load-use: lw in EX, dependent instruction in D → exactly one bubble. Dependent enters EX on the following edge, once lw has moved to MEM.
- stall_f/stall_d are valid in the same cycle as their inputs. There is no registered path, so no combinational loop with flush.
- Reset is asynchronous assert. Release is sampled on the next rising edge. Reset mid-stall clears stall outputs immediately, because valid_e becomes 0.

## Configuration
- ID_EX_HAZARD_EN defined: hazard detection, bubble insertion and bubble_cnt as above.
- Undefined: hz is constant 0.
  - stall_f/stall_d = ~flush & ex_hold.
  - bubble_cnt is tied to 0.
  - Forwarding and compiler scheduling are then responsible for load-use hazards.

## Test plan
- Reset mid-run: assert rst asynchronously with valid_e=1, regWrite_e=1 → all outputs 0 before the next edge; bubble_cnt=0.
- Pass-through: add (opCode 0, funct 100000), rs=1, rt=2, rd=3, rd1=5, rd2=7, valid_d=1 → next cycle regWrite_e=1, RegDst_e=1, aluControl_e=010, rd1_e=5, rd2_e=7, valid_e=1; stalls 0.
- Load-use: lw rt=4 in EX, then sub with rs_d=4 → stall_f=stall_d=1 for one cycle. One bubble (valid_e=0, memWrite_e=0), then sub enters EX; bubble_cnt=1.
- No false stall:
  - lw rt=4 in EX, then lw rs_d=5, rt_d=4, rt_used_d=0 → no stall.
  - lw rt=0 in EX, then add rs_d=0 → no stall.
- Flush priority: hz=1, flush=1 and ex_hold=1 in the same cycle → stalls 0, bubble loaded, bubble_cnt unchanged.
- Hold and saturation:
  - ex_hold=1 for 3 cycles → *_e unchanged and stalls 1.
  - CNT_W=2 with 5 consecutive hazards → bubble_cnt reads 3.
  - Macro undefined → no stalls on the load-use case.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode/execute bundle for the ID/EX pipeline stage
//
// Purpose: carries the decode-stage control word and operands into the
// ID/EX register, the registered execute-side copies back out, the
// pipeline control inputs (flush, ex_hold) and the stall/bubble-count
// outputs.
//
// Modports:
//   master : drives *_d, rt_used_d, valid_d, flush, ex_hold;
//            observes *_e, valid_e, stall_f, stall_d, bubble_cnt
//   slave  : the ID/EX stage itself (mirror of master)
//
// Parameters: DATA_W (datapath width), REG_W (register-address width),
//             CNT_W (bubble-counter width)
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
);
  // Decode side
  logic              regWrite_d, aluSrc_d, memWrite_d, memToReg_d, memRead_d, RegDst_d;
  logic [2:0]        aluControl_d;
  logic [DATA_W-1:0] rd1_d, rd2_d, imm_d, pc4_d;
  logic [REG_W-1:0]  rs_d, rt_d, rd_d;
  logic              rt_used_d;
  logic              valid_d;

  // Pipeline control
  logic              flush;
  logic              ex_hold;

  // Execute side
  logic              regWrite_e, aluSrc_e, memWrite_e, memToReg_e, memRead_e, RegDst_e;
  logic [2:0]        aluControl_e;
  logic [DATA_W-1:0] rd1_e, rd2_e, imm_e, pc4_e;
  logic [REG_W-1:0]  rs_e, rt_e, rd_e;
  logic              valid_e;

  // Stalls and statistics
  logic              stall_f, stall_d;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output regWrite_d, aluSrc_d, memWrite_d, memToReg_d, memRead_d, RegDst_d,
           aluControl_d, rd1_d, rd2_d, imm_d, pc4_d, rs_d, rt_d, rd_d,
           rt_used_d, valid_d, flush, ex_hold,
    input  regWrite_e, aluSrc_e, memWrite_e, memToReg_e, memRead_e, RegDst_e,
           aluControl_e, rd1_e, rd2_e, imm_e, pc4_e, rs_e, rt_e, rd_e,
           valid_e, stall_f, stall_d, bubble_cnt
  );

  modport slave (
    input  regWrite_d, aluSrc_d, memWrite_d, memToReg_d, memRead_d, RegDst_d,
           aluControl_d, rd1_d, rd2_d, imm_d, pc4_d, rs_d, rt_d, rd_d,
           rt_used_d, valid_d, flush, ex_hold,
    output regWrite_e, aluSrc_e, memWrite_e, memToReg_e, memRead_e, RegDst_e,
           aluControl_e, rd1_e, rd2_e, imm_e, pc4_e, rs_e, rt_e, rd_e,
           valid_e, stall_f, stall_d, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard control
//
// Purpose: registers the decode control word and operands into EX, inserts
// a bubble on branch/jump flush or on a load-use hazard, freezes on
// ex_hold, and drives the PC and IF/ID stall lines combinationally.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : id_ex_stage_if.slave (decode inputs, execute outputs,
//          flush/ex_hold, stall_f/stall_d, bubble_cnt)
//
// Build option: ID_EX_HAZARD_EN enables load-use detection, bubble
// insertion and bubble_cnt. Without it the hazard term is 0 and
// bubble_cnt is tied to 0.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  // Control word layout: {regWrite, aluSrc, memWrite, memToReg, memRead, RegDst, aluControl[2:0]}
  localparam int C_MEMREAD = 4;

  logic [8:0]        w_ctrl_d;
  logic [8:0]        r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_imm, r_pc4;
  logic [REG_W-1:0]  r_rs, r_rt, r_rd;
  logic              w_hz;
  logic              w_bubble;

  assign w_ctrl_d = {bus.regWrite_d, bus.aluSrc_d, bus.memWrite_d, bus.memToReg_d,
                     bus.memRead_d, bus.RegDst_d, bus.aluControl_d};

`ifdef ID_EX_HAZARD_EN
  // Load in EX whose destination (rt) is read by the instruction in D.
  // $zero never creates a dependency; rt only counts when D actually reads it.
  assign w_hz = r_valid & r_ctrl[C_MEMREAD] & (r_rt != '0) & bus.valid_d &
                ((r_rt == bus.rs_d) | (bus.rt_used_d & (r_rt == bus.rt_d)));
`else
  assign w_hz = 1'b0;
`endif

  // Flush outranks hold; a hazard only bubbles when EX is free to advance.
  assign w_bubble = bus.flush | (~bus.ex_hold & w_hz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (w_bubble) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (!bus.ex_hold) begin
      // Invalid slots carry don't-care control from decode; force them inert.
      r_ctrl  <= bus.valid_d ? w_ctrl_d : 9'd0;
      r_valid <= bus.valid_d;
      r_rd1   <= bus.rd1_d;
      r_rd2   <= bus.rd2_d;
      r_imm   <= bus.imm_d;
      r_pc4   <= bus.pc4_d;
      r_rs    <= bus.rs_d;
      r_rt    <= bus.rt_d;
      r_rd    <= bus.rd_d;
    end
  end

`ifdef ID_EX_HAZARD_EN
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!bus.flush && !bus.ex_hold && w_hz && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.bubble_cnt = r_bubble_cnt;
`else
  assign bus.bubble_cnt = {CNT_W{1'b0}};
`endif

  assign bus.regWrite_e   = r_ctrl[8];
  assign bus.aluSrc_e     = r_ctrl[7];
  assign bus.memWrite_e   = r_ctrl[6];
  assign bus.memToReg_e   = r_ctrl[5];
  assign bus.memRead_e    = r_ctrl[C_MEMREAD];
  assign bus.RegDst_e     = r_ctrl[3];
  assign bus.aluControl_e = r_ctrl[2:0];
  assign bus.rd1_e        = r_rd1;
  assign bus.rd2_e        = r_rd2;
  assign bus.imm_e        = r_imm;
  assign bus.pc4_e        = r_pc4;
  assign bus.rs_e         = r_rs;
  assign bus.rt_e         = r_rt;
  assign bus.rd_e         = r_rd;
  assign bus.valid_e      = r_valid;

  // Purely combinational from registered EX state and current inputs:
  // no path from stall back into flush, so no loop.
  assign bus.stall_f = ~bus.flush & (bus.ex_hold | w_hz);
  assign bus.stall_d = ~bus.flush & (bus.ex_hold | w_hz);

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

`ifdef ID_EX_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  // {regWrite, aluSrc, memWrite, memToReg, memRead, RegDst, aluControl}
  localparam logic [8:0] C_NOP = 9'b000000000;
  localparam logic [8:0] C_ADD = 9'b100001010;
  localparam logic [8:0] C_SUB = 9'b100001110;
  localparam logic [8:0] C_LW  = 9'b110110010;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bus ();
  id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(2))  bus2 ();

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rtu, input logic v,
                       input logic [31:0] r1, input logic [31:0] r2);
    {bus.regWrite_d, bus.aluSrc_d, bus.memWrite_d, bus.memToReg_d,
     bus.memRead_d, bus.RegDst_d, bus.aluControl_d} = c;
    bus.rs_d      = rs;
    bus.rt_d      = rt;
    bus.rd_d      = rd;
    bus.rt_used_d = rtu;
    bus.valid_d   = v;
    bus.rd1_d     = r1;
    bus.rd2_d     = r2;
    bus.imm_d     = 32'h10;
    bus.pc4_d     = 32'h104;
  endtask

  task automatic drive2(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rtu, input logic v);
    {bus2.regWrite_d, bus2.aluSrc_d, bus2.memWrite_d, bus2.memToReg_d,
     bus2.memRead_d, bus2.RegDst_d, bus2.aluControl_d} = c;
    bus2.rs_d      = rs;
    bus2.rt_d      = rt;
    bus2.rd_d      = 5'd0;
    bus2.rt_used_d = rtu;
    bus2.valid_d   = v;
    bus2.rd1_d     = 32'd0;
    bus2.rd2_d     = 32'd0;
    bus2.imm_d     = 32'd0;
    bus2.pc4_d     = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.ex_hold  = 1'b0;
    bus2.flush   = 1'b0;
    bus2.ex_hold = 1'b0;
    drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive2(C_NOP, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    step();

    // Reset state
    check("rst_valid_e", bus.valid_e, 0);
    check("rst_regWrite_e", bus.regWrite_e, 0);
    check("rst_bubble_cnt", bus.bubble_cnt, 0);
    check("rst_stall_f", bus.stall_f, 0);
    rst = 1'b0;

    // Pass-through add
    drive(C_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd5, 32'd7);
    step();
    check("pt_regWrite_e", bus.regWrite_e, 1);
    check("pt_RegDst_e", bus.RegDst_e, 1);
    check("pt_aluControl_e", bus.aluControl_e, 3'b010);
    check("pt_rd1_e", bus.rd1_e, 5);
    check("pt_rd2_e", bus.rd2_e, 7);
    check("pt_rd_e", bus.rd_e, 3);
    check("pt_valid_e", bus.valid_e, 1);
    check("pt_stall_f", bus.stall_f, 0);
    check("pt_stall_d", bus.stall_d, 0);

    // Load-use: lw rt=4 then sub rs=4
    drive(C_LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b1, 32'd100, 32'd0);
    step();
    drive(C_SUB, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 32'd9, 32'd3);
    #1;
    check("lu_stall_f", bus.stall_f, HZ);
    check("lu_stall_d", bus.stall_d, HZ);
    step();
    check("lu_bub_valid_e", bus.valid_e, !HZ);
    check("lu_bub_memWrite_e", bus.memWrite_e, 0);
    check("lu_bub_regWrite_e", bus.regWrite_e, !HZ);
    check("lu_bub_cnt", bus.bubble_cnt, HZ ? 1 : 0);
    step();
    check("lu_sub_valid_e", bus.valid_e, 1);
    check("lu_sub_aluControl_e", bus.aluControl_e, 3'b110);
    check("lu_sub_rd_e", bus.rd_e, 6);
    check("lu_sub_cnt", bus.bubble_cnt, HZ ? 1 : 0);
    check("lu_sub_stall_f", bus.stall_f, 0);

    // No false stall: rt_d matches but rt not read
    drive(C_LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b1, 32'd0, 32'd0);
    step();
    drive(C_LW, 5'd5, 5'd4, 5'd0, 1'b0, 1'b1, 32'd0, 32'd0);
    #1;
    check("nfs_rt_unused_stall", bus.stall_f, 0);
    step();
    check("nfs_rt_unused_valid", bus.valid_e, 1);
    check("nfs_rt_unused_rs_e", bus.rs_e, 5);

    // No false stall: load into $zero
    drive(C_LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'd0, 32'd0);
    step();
    drive(C_ADD, 5'd0, 5'd2, 5'd3, 1'b1, 1'b1, 32'd0, 32'd0);
    #1;
    check("nfs_zero_stall", bus.stall_f, 0);
    step();
    check("nfs_zero_valid", bus.valid_e, 1);
    check("nfs_zero_cnt", bus.bubble_cnt, HZ ? 1 : 0);

    // Flush beats hazard and hold
    drive(C_LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b1, 32'd0, 32'd0);
    step();
    drive(C_SUB, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 32'd9, 32'd3);
    bus.flush   = 1'b1;
    bus.ex_hold = 1'b1;
    #1;
    check("fl_stall_f", bus.stall_f, 0);
    check("fl_stall_d", bus.stall_d, 0);
    step();
    check("fl_valid_e", bus.valid_e, 0);
    check("fl_memRead_e", bus.memRead_e, 0);
    check("fl_regWrite_e", bus.regWrite_e, 0);
    check("fl_rd1_e", bus.rd1_e, 0);
    check("fl_cnt", bus.bubble_cnt, HZ ? 1 : 0);
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b0;

    // Hold for three cycles
    drive(C_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd5, 32'd7);
    step();
    bus.ex_hold = 1'b1;
    drive(C_SUB, 5'd9, 5'd8, 5'd7, 1'b1, 1'b1, 32'd11, 32'd12);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold%0d_stall_f", i), bus.stall_f, 1);
      check($sformatf("hold%0d_stall_d", i), bus.stall_d, 1);
      step();
      check($sformatf("hold%0d_rd1_e", i), bus.rd1_e, 5);
      check($sformatf("hold%0d_aluControl_e", i), bus.aluControl_e, 3'b010);
    end
    bus.ex_hold = 1'b0;

    // Hazard under hold: no count, then bubble once hold drops
    drive(C_LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b1, 32'd0, 32'd0);
    step();
    drive(C_SUB, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 32'd9, 32'd3);
    bus.ex_hold = 1'b1;
    step();
    check("hh_valid_e", bus.valid_e, 1);
    check("hh_memRead_e", bus.memRead_e, 1);
    check("hh_cnt", bus.bubble_cnt, HZ ? 1 : 0);
    bus.ex_hold = 1'b0;
    step();
    check("hh_rel_cnt", bus.bubble_cnt, HZ ? 2 : 0);
    check("hh_rel_valid_e", bus.valid_e, !HZ);

    // Invalid slot: control sanitised, data still loads
    drive(9'h1FF, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h55, 32'd0);
    step();
    check("inv_regWrite_e", bus.regWrite_e, 0);
    check("inv_memWrite_e", bus.memWrite_e, 0);
    check("inv_memRead_e", bus.memRead_e, 0);
    check("inv_valid_e", bus.valid_e, 0);
    check("inv_rd1_e", bus.rd1_e, 32'h55);

    // Saturation on a 2-bit counter over five load-use events
    for (int i = 0; i < 5; i++) begin
      drive2(C_LW, 5'd1, 5'd4, 1'b0, 1'b1);
      step();
      drive2(C_SUB, 5'd4, 5'd5, 1'b1, 1'b1);
      step();
      check($sformatf("sat%0d_cnt", i), bus2.bubble_cnt, HZ ? ((i + 1 > 3) ? 3 : i + 1) : 0);
    end

    // Asynchronous reset in the middle of a stall
    drive(C_LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b1, 32'd77, 32'd0);
    step();
    drive(C_SUB, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 32'd9, 32'd3);
    #1;
    check("ar_pre_stall_f", bus.stall_f, HZ);
    check("ar_pre_regWrite_e", bus.regWrite_e, 1);
    #1;
    rst = 1'b1;
    #1;
    check("ar_valid_e", bus.valid_e, 0);
    check("ar_regWrite_e", bus.regWrite_e, 0);
    check("ar_rd1_e", bus.rd1_e, 0);
    check("ar_stall_f", bus.stall_f, 0);
    check("ar_stall_d", bus.stall_d, 0);
    check("ar_cnt", bus.bubble_cnt, 0);
    check("ar_sat_cnt", bus2.bubble_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
